// File: rtl/mem_compare_scanner.sv
// mem_compare_scanner
//   Checker that sits downstream of a behavioural/structural memory pair
//   sharing one address bus. On i_start it takes over the address bus,
//   reads every word once, and compares the two read ports. It reports
//   the number of differing words, the lowest differing address and the
//   OR of all bit differences. While not busy, the host's address and
//   write enable pass straight through to the memories.
//
// Ports
//   i_clk                  system clock, rising edge
//   i_reset                synchronous active-high reset
//   i_start                scan request, honoured only in IDLE or DONE
//   i_host_address         host address, forwarded when not busy
//   i_host_write_enable    host write enable, forwarded when not busy
//   o_address              address to both memories
//   o_write_enable         write enable to both memories
//   i_bm_data / i_sm_data  read data from the two memories
//   o_busy                 scan in progress (SCAN or DRAIN)
//   o_done                 scan finished, results valid (level)
//   o_mismatch_count       number of differing words (0..DEPTH)
//   o_first_mismatch_valid at least one difference seen this scan
//   o_first_mismatch_addr  lowest differing address
//   o_diff_mask            OR over all words of bm ^ sm
//
// state | meaning
// IDLE  | host owns the bus, no results yet
// SCAN  | issuing addresses 0..DEPTH-1, one per cycle
// DRAIN | all addresses issued, waiting for in-flight reads
// DONE  | results final and held, host owns the bus
module mem_compare_scanner #(
  parameter int ADDR_WIDTH   = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_host_address,
  input  logic                  i_host_write_enable,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_write_enable,
  input  logic [DATA_WIDTH-1:0] i_bm_data,
  input  logic [DATA_WIDTH-1:0] i_sm_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_mismatch_count,
  output logic                  o_first_mismatch_valid,
  output logic [ADDR_WIDTH-1:0] o_first_mismatch_addr,
  output logic [DATA_WIDTH-1:0] o_diff_mask
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_scan_addr;
  logic                  w_issue;
  logic                  w_start_ok;
  logic                  w_cmp_valid;
  logic [ADDR_WIDTH-1:0] w_cmp_addr;
  logic                  w_pipe_pending;
  logic                  w_differs;

  logic [ADDR_WIDTH:0]   r_mismatch_count;
  logic                  r_first_valid;
  logic [ADDR_WIDTH-1:0] r_first_addr;
  logic [DATA_WIDTH-1:0] r_diff_mask;

  assign w_issue    = (r_state == S_SCAN);
  assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_differs  = (i_bm_data != i_sm_data);

  // Read tracking: the compare stage sees the valid flag and address of
  // the read whose data is on the bus this cycle.
  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      assign w_cmp_valid    = w_issue;
      assign w_cmp_addr     = r_scan_addr;
      assign w_pipe_pending = 1'b0;
    end else begin : g_pipe
      logic [READ_LATENCY-1:0] r_pv;
      logic [ADDR_WIDTH-1:0]   r_pa [READ_LATENCY];

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_pv <= '0;
          for (int j = 0; j < READ_LATENCY; j++) r_pa[j] <= '0;
        end else begin
          r_pv[0] <= w_issue;
          r_pa[0] <= r_scan_addr;
          for (int j = 1; j < READ_LATENCY; j++) begin
            r_pv[j] <= r_pv[j-1];
            r_pa[j] <= r_pa[j-1];
          end
        end
      end

      assign w_cmp_valid = r_pv[READ_LATENCY-1];
      assign w_cmp_addr  = r_pa[READ_LATENCY-1];

      // DRAIN can leave once only the read being compared right now is
      // left; any valid in an earlier stage still has to arrive.
      if (READ_LATENCY == 1) begin : g_pend1
        assign w_pipe_pending = 1'b0;
      end else begin : g_pendn
        assign w_pipe_pending = |r_pv[READ_LATENCY-2:0];
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    o_busy         = 1'b0;
    o_done         = 1'b0;
    o_address      = i_host_address;
    o_write_enable = i_host_write_enable;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) w_state_next = S_SCAN;
      end
      S_SCAN: begin
        o_busy         = 1'b1;
        o_address      = r_scan_addr;
        o_write_enable = 1'b0;
        if (r_scan_addr == LAST_ADDR)
          w_state_next = (READ_LATENCY == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        o_busy         = 1'b1;
        o_address      = r_scan_addr;
        o_write_enable = 1'b0;
        if (!w_pipe_pending) w_state_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        if (i_start) w_state_next = S_SCAN;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Scan address parks on the last word rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_start_ok)
      r_scan_addr <= '0;
    else if (w_issue && (r_scan_addr != LAST_ADDR))
      r_scan_addr <= r_scan_addr + 1'b1;
  end

  // The pipeline is empty in IDLE/DONE, so clearing on start never
  // collides with a compare.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_start_ok) begin
      r_mismatch_count <= '0;
      r_first_valid    <= 1'b0;
      r_first_addr     <= '0;
      r_diff_mask      <= '0;
    end else if (w_cmp_valid && w_differs) begin
      r_mismatch_count <= r_mismatch_count + 1'b1;
      r_diff_mask      <= r_diff_mask | (i_bm_data ^ i_sm_data);
      if (!r_first_valid) begin
        r_first_valid <= 1'b1;
        r_first_addr  <= w_cmp_addr;
      end
    end
  end

  assign o_mismatch_count       = r_mismatch_count;
  assign o_first_mismatch_valid = r_first_valid;
  assign o_first_mismatch_addr  = r_first_addr;
  assign o_diff_mask            = r_diff_mask;

endmodule

// File: tb/tb_mem_compare_scanner.sv
// Bench for mem_compare_scanner: two instances share one pair of memory
// arrays, one with a registered read (latency 1) and one with a
// combinational read (latency 0). Expected results come from a plain
// walk over the arrays.
module tb_mem_compare_scanner;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int NOBS = 14;
  localparam int RW = AW + 1 + 1 + AW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, host_we;
  logic [AW-1:0] host_address;
  logic [DW-1:0] bm_mem [DEPTH];
  logic [DW-1:0] sm_mem [DEPTH];

  logic [AW-1:0] addr1, faddr1, addr0, faddr0;
  logic          we1, busy1, done1, fmv1, we0, busy0, done0, fmv0;
  logic [AW:0]   cnt1, cnt0;
  logic [DW-1:0] mask1, bm_q1, sm_q1, mask0, bm_d0, sm_d0;

  always @(posedge clk) begin
    bm_q1 <= bm_mem[addr1];
    sm_q1 <= sm_mem[addr1];
  end
  assign bm_d0 = bm_mem[addr0];
  assign sm_d0 = sm_mem[addr0];

  mem_compare_scanner #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_host_address(host_address), .i_host_write_enable(host_we),
    .o_address(addr1), .o_write_enable(we1),
    .i_bm_data(bm_q1), .i_sm_data(sm_q1),
    .o_busy(busy1), .o_done(done1), .o_mismatch_count(cnt1),
    .o_first_mismatch_valid(fmv1), .o_first_mismatch_addr(faddr1),
    .o_diff_mask(mask1));

  mem_compare_scanner #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(0)) u_dut0 (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_host_address(host_address), .i_host_write_enable(host_we),
    .o_address(addr0), .o_write_enable(we0),
    .i_bm_data(bm_d0), .i_sm_data(sm_d0),
    .o_busy(busy0), .o_done(done0), .o_mismatch_count(cnt0),
    .o_first_mismatch_valid(fmv0), .o_first_mismatch_addr(faddr0),
    .o_diff_mask(mask0));

  int checks = 0;
  int failures = 0;

  // observations per cycle n after the start edge k (sampled at negedge)
  logic          obs_busy1 [NOBS], obs_busy0 [NOBS], obs_done1 [NOBS], obs_done0 [NOBS];
  logic          obs_we1 [NOBS], obs_we0 [NOBS];
  logic [AW-1:0] obs_addr1 [NOBS], obs_addr0 [NOBS], obs_host [NOBS];
  logic [RW-1:0] obs_res1 [NOBS], obs_res0 [NOBS];
  int            done_n1, done_n0;

  logic [AW:0]   exp_cnt;
  logic          exp_fv;
  logic [AW-1:0] exp_first;
  logic [DW-1:0] exp_mask;
  logic [RW-1:0] exp_res;

  task automatic compute_model();
    exp_cnt = '0; exp_fv = 1'b0; exp_first = '0; exp_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bm_mem[i] !== sm_mem[i]) begin
        exp_cnt  = exp_cnt + 1'b1;
        exp_mask = exp_mask | (bm_mem[i] ^ sm_mem[i]);
        if (!exp_fv) begin exp_fv = 1'b1; exp_first = AW'(i); end
      end
    end
    exp_res = {exp_cnt, exp_fv, exp_first, exp_mask};
  endtask

  task automatic load_same();
    for (int i = 0; i < DEPTH; i++) begin
      bm_mem[i] = 32'h1000_0000 + i;
      sm_mem[i] = 32'h1000_0000 + i;
    end
  endtask

  // Pulses start, then records outputs for NOBS cycles. restart_at / reset_at
  // name the edge offset at which start / reset is sampled high (-1: never).
  task automatic run_scan(input int restart_at, input int reset_at);
    @(negedge clk);
    start = 1'b1; host_we = 1'b1; host_address = AW'($urandom);
    @(posedge clk);
    for (int n = 0; n < NOBS; n++) begin
      @(negedge clk);
      obs_busy1[n] = busy1; obs_done1[n] = done1; obs_we1[n] = we1; obs_addr1[n] = addr1;
      obs_busy0[n] = busy0; obs_done0[n] = done0; obs_we0[n] = we0; obs_addr0[n] = addr0;
      obs_res1[n] = {cnt1, fmv1, faddr1, mask1};
      obs_res0[n] = {cnt0, fmv0, faddr0, mask0};
      obs_host[n] = host_address;
      start = (n + 1 == restart_at);
      reset = (n + 1 == reset_at);
      host_address = AW'($urandom);
    end
    start = 1'b0; reset = 1'b0;
    done_n1 = -1; done_n0 = -1;
    for (int n = NOBS - 1; n >= 0; n--) begin
      if (obs_done1[n]) done_n1 = n;
      if (obs_done0[n]) done_n0 = n;
    end
  endtask

  task automatic check_results(input string tag);
    compute_model();
    checks++;
    if (done_n1 !== DEPTH + 1) begin
      failures++; $display("FAIL %s done_edge_lat1 got=%0d want=%0d", tag, done_n1, DEPTH + 1);
    end
    checks++;
    if (done_n0 !== DEPTH) begin
      failures++; $display("FAIL %s done_edge_lat0 got=%0d want=%0d", tag, done_n0, DEPTH);
    end
    checks++;
    if (obs_res1[DEPTH+1] !== exp_res) begin
      failures++; $display("FAIL %s results_at_done_lat1 got=%h want=%h", tag, obs_res1[DEPTH+1], exp_res);
    end
    checks++;
    if (obs_res0[DEPTH] !== exp_res) begin
      failures++; $display("FAIL %s results_at_done_lat0 got=%h want=%h", tag, obs_res0[DEPTH], exp_res);
    end
    checks++;
    if ({cnt1, fmv1, faddr1, mask1, done1} !== {exp_res, 1'b1}) begin
      failures++; $display("FAIL %s results_held_lat1 got=%h/%b want=%h/1", tag, {cnt1, fmv1, faddr1, mask1}, done1, exp_res);
    end
    checks++;
    if ({cnt0, fmv0, faddr0, mask0, done0} !== {exp_res, 1'b1}) begin
      failures++; $display("FAIL %s results_held_lat0 got=%h/%b want=%h/1", tag, {cnt0, fmv0, faddr0, mask0}, done0, exp_res);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; host_address = 3'd5; host_we = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy1, done1, cnt1, fmv1, faddr1, mask1, addr1, we1} !== {2'b00, {RW{1'b0}}, 3'd5, 1'b1}) begin
      failures++; $display("FAIL reset_state_lat1 got busy=%b done=%b res=%h addr=%0d we=%b want 0/0/0/5/1",
                           busy1, done1, {cnt1, fmv1, faddr1, mask1}, addr1, we1);
    end
    checks++;
    if ({busy0, done0, cnt0, fmv0, faddr0, mask0, addr0, we0} !== {2'b00, {RW{1'b0}}, 3'd5, 1'b1}) begin
      failures++; $display("FAIL reset_state_lat0 got busy=%b done=%b res=%h addr=%0d we=%b want 0/0/0/5/1",
                           busy0, done0, {cnt0, fmv0, faddr0, mask0}, addr0, we0);
    end
    start = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy1, busy0} !== 2'b00) begin
      failures++; $display("FAIL reset_dominates_start got busy=%b%b want 00", busy1, busy0);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identical();
    load_same();
    run_scan(-1, -1);
    for (int n = 0; n < DEPTH; n++) begin
      checks++;
      if ({obs_busy1[n], obs_we1[n], obs_addr1[n]} !== {2'b10, AW'(n)}) begin
        failures++; $display("FAIL sweep_lat1 n=%0d got busy=%b we=%b addr=%0d want 1/0/%0d", n, obs_busy1[n], obs_we1[n], obs_addr1[n], n);
      end
      checks++;
      if ({obs_busy0[n], obs_we0[n], obs_addr0[n]} !== {2'b10, AW'(n)}) begin
        failures++; $display("FAIL sweep_lat0 n=%0d got busy=%b we=%b addr=%0d want 1/0/%0d", n, obs_busy0[n], obs_we0[n], obs_addr0[n], n);
      end
    end
    checks++;
    if ({obs_busy1[DEPTH], obs_busy1[DEPTH+1], obs_busy0[DEPTH]} !== 3'b100) begin
      failures++; $display("FAIL busy_tail got lat1=%b%b lat0=%b want 10/0", obs_busy1[DEPTH], obs_busy1[DEPTH+1], obs_busy0[DEPTH]);
    end
    checks++;
    if ({obs_addr1[DEPTH+2], obs_we1[DEPTH+2]} !== {obs_host[DEPTH+2], 1'b1}) begin
      failures++; $display("FAIL host_passthrough_done got addr=%0d we=%b want %0d/1", obs_addr1[DEPTH+2], obs_we1[DEPTH+2], obs_host[DEPTH+2]);
    end
    check_results("identical");
  endtask

  task automatic test_single();
    load_same();
    bm_mem[5] = 32'h0000_0005; sm_mem[5] = 32'h0000_0004;
    run_scan(-1, -1);
    checks++;
    if ({cnt1, fmv1, faddr1, mask1} !== {4'd1, 1'b1, 3'd5, 32'h0000_0001}) begin
      failures++; $display("FAIL single_literal got=%h want=%h", {cnt1, fmv1, faddr1, mask1}, {4'd1, 1'b1, 3'd5, 32'h0000_0001});
    end
    check_results("single");
  endtask

  task automatic load_two();
    load_same();
    sm_mem[2] = bm_mem[2] ^ 32'hFF00_0000;
    sm_mem[7] = bm_mem[7] ^ 32'h0000_00F0;
  endtask

  task automatic test_two();
    load_two();
    run_scan(-1, -1);
    checks++;
    if ({cnt1, fmv1, faddr1, mask1} !== {4'd2, 1'b1, 3'd2, 32'hFF00_00F0}) begin
      failures++; $display("FAIL two_literal got=%h want=%h", {cnt1, fmv1, faddr1, mask1}, {4'd2, 1'b1, 3'd2, 32'hFF00_00F0});
    end
    check_results("two");
  endtask

  task automatic test_all_diff_restart();
    load_same();
    for (int i = 0; i < DEPTH; i++) sm_mem[i] = bm_mem[i] ^ 32'h8000_0001;
    run_scan(-1, -1);
    checks++;
    if ({cnt1, faddr1} !== {4'b1000, 3'd0}) begin
      failures++; $display("FAIL all_diff_count got cnt=%b first=%0d want 1000/0", cnt1, faddr1);
    end
    check_results("all_diff");
    run_scan(-1, -1);
    checks++;
    if ({obs_res1[0], obs_done1[0], obs_busy1[0]} !== {{RW{1'b0}}, 2'b01}) begin
      failures++; $display("FAIL restart_clear_lat1 got res=%h done=%b busy=%b want 0/0/1", obs_res1[0], obs_done1[0], obs_busy1[0]);
    end
    checks++;
    if ({obs_res0[0], obs_done0[0], obs_busy0[0]} !== {{RW{1'b0}}, 2'b01}) begin
      failures++; $display("FAIL restart_clear_lat0 got res=%h done=%b busy=%b want 0/0/1", obs_res0[0], obs_done0[0], obs_busy0[0]);
    end
    check_results("rescan");
  endtask

  task automatic test_reset_mid_scan();
    // memory still all-different from the previous test
    run_scan(-1, 4);
    checks++;
    if ({obs_res1[3][RW-1:RW-AW-1], obs_res0[3][RW-1:RW-AW-1]} !== {4'd2, 4'd3}) begin
      failures++; $display("FAIL partial_count got lat1=%0d lat0=%0d want 2/3", obs_res1[3][RW-1:RW-AW-1], obs_res0[3][RW-1:RW-AW-1]);
    end
    checks++;
    if ({obs_busy1[4], obs_done1[4], obs_res1[4], obs_addr1[4], obs_we1[4]} !== {2'b00, {RW{1'b0}}, obs_host[4], 1'b1}) begin
      failures++; $display("FAIL mid_reset_lat1 got busy=%b done=%b res=%h addr=%0d we=%b want 0/0/0/%0d/1",
                           obs_busy1[4], obs_done1[4], obs_res1[4], obs_addr1[4], obs_we1[4], obs_host[4]);
    end
    checks++;
    if ({obs_busy0[4], obs_done0[4], obs_res0[4], obs_addr0[4]} !== {2'b00, {RW{1'b0}}, obs_host[4]}) begin
      failures++; $display("FAIL mid_reset_lat0 got busy=%b done=%b res=%h addr=%0d want 0/0/0/%0d",
                           obs_busy0[4], obs_done0[4], obs_res0[4], obs_addr0[4], obs_host[4]);
    end
    checks++;
    if ({done_n1, done_n0} !== {-32'sd1, -32'sd1} || {cnt1, cnt0, busy1, busy0} !== '0) begin
      failures++; $display("FAIL mid_reset_stays_idle got done_n=%0d/%0d cnt=%0d/%0d busy=%b%b want -1/-1 0/0 00",
                           done_n1, done_n0, cnt1, cnt0, busy1, busy0);
    end
  endtask

  task automatic test_start_while_busy();
    load_two();
    run_scan(3, -1);
    checks++;
    if ({obs_addr1[3], obs_addr1[4], obs_addr0[3], obs_addr0[4]} !== {3'd3, 3'd4, 3'd3, 3'd4}) begin
      failures++; $display("FAIL start_busy_addr got lat1=%0d,%0d lat0=%0d,%0d want 3,4", obs_addr1[3], obs_addr1[4], obs_addr0[3], obs_addr0[4]);
    end
    check_results("start_busy");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        bm_mem[i] = $urandom;
        sm_mem[i] = ($urandom_range(0, 2) == 0) ? (bm_mem[i] ^ $urandom) : bm_mem[i];
      end
      run_scan(-1, -1);
      check_results($sformatf("random%0d", it));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; host_we = 1'b0; host_address = '0;
    load_same();
    test_reset();
    test_identical();
    test_single();
    test_two();
    test_all_diff_restart();
    test_reset_mid_scan();
    test_start_while_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_compare_scanner.md
Name: mem_compare_scanner

Overview:
- Downstream checker for the dual memory pair (behavioural bm and structural sm, 2^ADDR_WIDTH words × DATA_WIDTH).
- On `start`, it takes over the shared read address and sweeps every word once. It compares `bm_data` against `sm_data` and reports mismatch count, first failing address and an accumulated bit-difference mask.
- When idle it passes the host's address and write_enable straight through to the memories.

Parameters:
- ADDR_WIDTH, 3, memory address width; DEPTH = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, memory word width.
- READ_LATENCY, 1, clock edges from address presented to data valid on `bm_data`/`sm_data`. Legal range is 0..3.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a full scan; sampled only in IDLE or DONE.
- host_address  in  ADDR_WIDTH  host address, forwarded when not busy.
- host_write_enable  in  1  host write enable, forwarded when not busy.
- address  out  ADDR_WIDTH  address driven to both memories.
- write_enable  out  1  write enable driven to both memories.
- bm_data  in  DATA_WIDTH  behavioural memory read data.
- sm_data  in  DATA_WIDTH  structural memory read data.
- busy  out  1  high in SCAN and DRAIN.
- done  out  1  high in DONE (level, held until next start or reset).
- mismatch_count  out  ADDR_WIDTH+1  number of words whose data differed.
- first_mismatch_valid  out  1  at least one mismatch seen this scan.
- first_mismatch_addr  out  ADDR_WIDTH  address of lowest-index mismatch.
- diff_mask  out  DATA_WIDTH  OR over all words of (bm_data XOR sm_data).

Behaviour:
- States:
  - IDLE
  - SCAN: issue addresses.
  - DRAIN: wait for in-flight reads.
  - DONE
- Reset (sync, dominant over all other inputs):
  - state = IDLE; internal scan address and in-flight pipeline cleared.
  - busy, done, mismatch_count, first_mismatch_valid, first_mismatch_addr and diff_mask = 0.
  - Reset mid-scan discards the scan entirely; no partial results are kept.
- Output mux (combinational):
  - busy = 0: address = host_address, write_enable = host_write_enable.
  - busy = 1: address = internal scan address, write_enable = 0.
- IDLE/DONE + start = 1 at edge k:
  - go to SCAN; scan address = 0.
  - All result outputs cleared at that same edge.
  - done falls and busy rises at edge k.
- SCAN:
  - Address i (0..DEPTH-1) is presented in the cycle following edge k+i.
  - A READ_LATENCY-deep valid/address shift pipeline tracks each issued read.
  - At the edge that issues DEPTH-1 (edge k+DEPTH-1 presents it), the next edge moves the state to DRAIN. The scan address does not wrap or increment past DEPTH-1.
- Compare:
  - Data for address i is valid in the cycle following edge k+i+READ_LATENCY.
  - It is compared and registered at edge k+i+READ_LATENCY+1.
  - On mismatch: mismatch_count += 1; diff_mask |= bm_data ^ sm_data.
  - If first_mismatch_valid = 0, set first_mismatch_valid = 1 and first_mismatch_addr = i.
- DRAIN:
  - Remain until the pipeline is empty, then go to DONE.
  - With READ_LATENCY = 0, DRAIN is skipped (SCAN goes directly to DONE).
- DONE timing:
  - done rises at edge k+DEPTH+READ_LATENCY (edge k+9 for defaults).
  - The final comparison is registered at that same edge, so results are stable when done is seen high.
- start while busy: ignored, no restart, no effect on results.
- Counter width: mismatch_count holds 0..DEPTH without overflow (max 4'b1000 at defaults).
- Results hold unchanged in DONE indefinitely.
- Host address/write_enable changes while busy have no effect on the memories.

Test Plan:
- Both memories loaded identically (word i = 32'h1000_0000+i), pulse start at edge k:
  - busy = 1 from edge k; address sweeps 0..7; write_enable = 0 throughout.
  - done = 1 at edge k+9; mismatch_count = 0, first_mismatch_valid = 0, diff_mask = 0.
- Single mismatch, sm word 5 = 32'h0000_0004 vs bm 32'h0000_0005:
  - mismatch_count = 1, first_mismatch_addr = 5, first_mismatch_valid = 1, diff_mask = 32'h0000_0001.
- Mismatches at addr 2 (diff 32'hFF00_0000) and addr 7 (diff 32'h0000_00F0):
  - mismatch_count = 2, first_mismatch_addr = 2, diff_mask = 32'hFF00_00F0.
- All 8 words differ:
  - mismatch_count = 4'b1000, first_mismatch_addr = 0.
  - start re-pulsed in DONE: results clear at that edge and rescan reproduces 8.
- Reset asserted during SCAN:
  - Assert at edge k+4: next cycle all outputs = 0, state IDLE, address follows host_address.
  - Separately, start pulsed at edge k+3 of a scan is ignored and done still rises at k+9.
- READ_LATENCY = 0 build with a combinational-read model, mismatch at addr 7:
  - done at edge k+8; mismatch_count = 1, first_mismatch_addr = 7.
